// File: rtl/fft_peak_bin_finder.sv
// fft_peak_bin_finder
// Scans one FFT frame of packed squared magnitudes (BUFFER_SIZE lanes per
// beat, NUM_BINS bins per frame) and reports the bin holding the largest
// magnitude, earliest bin winning ties, through a valid/ready handshake.
// Optional feature macro: FFT_PEAK_THRESHOLD_EN adds peak_threshold/peak_found.
module fft_peak_bin_finder #(
  parameter int SAMPLE_SIZE = 32,
  parameter int BUFFER_SIZE = 4,
  parameter int NUM_BINS    = 32
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [BUFFER_SIZE*SAMPLE_SIZE-1:0] in_mags,
  input  logic                               in_valid,
  output logic                               in_ready,
`ifdef FFT_PEAK_THRESHOLD_EN
  input  logic [SAMPLE_SIZE-1:0]             peak_threshold,
  output logic                               peak_found,
`endif
  output logic [$clog2(NUM_BINS)-1:0]        peak_index,
  output logic [SAMPLE_SIZE-1:0]             peak_mag,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [15:0]                        frame_count
);

  localparam int IDX_W  = $clog2(NUM_BINS);
  localparam int BEATS  = NUM_BINS / BUFFER_SIZE;
  localparam int CNT_W  = $clog2(BEATS);
  localparam int LANE_W = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  logic [1:0]             state;
  logic [CNT_W-1:0]       beat_cnt;
  logic [SAMPLE_SIZE-1:0] run_mag;
  logic [IDX_W-1:0]       run_idx;

  logic [SAMPLE_SIZE-1:0] lane_mag;
  logic [LANE_W-1:0]      lane_sel;
  logic [IDX_W-1:0]       beat_idx;
  logic [SAMPLE_SIZE-1:0] next_mag;
  logic [IDX_W-1:0]       next_idx;
  logic                   accept;
  logic                   last_beat;

`ifdef FFT_PEAK_THRESHOLD_EN
  logic [SAMPLE_SIZE-1:0] thr_q;
`endif

  assign in_ready  = (state != ST_HOLD);
  assign accept    = in_valid && in_ready;
  assign last_beat = (state == ST_ACCUM) && (beat_cnt == CNT_W'(BEATS - 1));
  assign beat_idx  = IDX_W'(beat_cnt) * IDX_W'(BUFFER_SIZE) + IDX_W'(lane_sel);

  // Reduce the lanes of the current beat to one winner; strict compare keeps the lower lane on ties.
  always_comb begin
    lane_mag = in_mags[SAMPLE_SIZE-1:0];
    lane_sel = '0;
    for (int k = 1; k < BUFFER_SIZE; k++) begin
      if (in_mags[k*SAMPLE_SIZE +: SAMPLE_SIZE] > lane_mag) begin
        lane_mag = in_mags[k*SAMPLE_SIZE +: SAMPLE_SIZE];
        lane_sel = LANE_W'(k);
      end
    end
  end

  // Merge the beat winner into the running max; the first beat of a frame seeds it unconditionally.
  always_comb begin
    next_mag = run_mag;
    next_idx = run_idx;
    if (state == ST_IDLE || lane_mag > run_mag) begin
      next_mag = lane_mag;
      next_idx = beat_idx;
    end
  end

  // Frame sequencing: seed in IDLE, accumulate in ACCUM, present the result in HOLD until taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      beat_cnt    <= '0;
      run_mag     <= '0;
      run_idx     <= '0;
      peak_index  <= '0;
      peak_mag    <= '0;
      out_valid   <= 1'b0;
      frame_count <= 16'd0;
`ifdef FFT_PEAK_THRESHOLD_EN
      thr_q       <= '0;
      peak_found  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            run_mag  <= next_mag;
            run_idx  <= next_idx;
            beat_cnt <= CNT_W'(1);
`ifdef FFT_PEAK_THRESHOLD_EN
            thr_q    <= peak_threshold;
`endif
            state    <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (accept) begin
            if (last_beat) begin
              peak_index  <= next_idx;
              peak_mag    <= next_mag;
              out_valid   <= 1'b1;
              frame_count <= frame_count + 16'd1;
`ifdef FFT_PEAK_THRESHOLD_EN
              peak_found  <= (next_mag > thr_q);
`endif
              beat_cnt    <= '0;
              state       <= ST_HOLD;
            end else begin
              run_mag  <= next_mag;
              run_idx  <= next_idx;
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_peak_bin_finder.sv
// Testbench for fft_peak_bin_finder: random and directed frames, expected
// results queued by a frame-level reference model, checked by a monitor.
module tb_fft_peak_bin_finder;

  localparam int SAMPLE_SIZE = 32;
  localparam int BUFFER_SIZE = 4;
  localparam int NUM_BINS    = 32;
  localparam int BEATS       = NUM_BINS / BUFFER_SIZE;
  localparam int IDX_W       = $clog2(NUM_BINS);

  logic                               clk = 1'b0;
  logic                               reset;
  logic [BUFFER_SIZE*SAMPLE_SIZE-1:0] in_mags;
  logic                               in_valid;
  logic                               in_ready;
  logic [IDX_W-1:0]                   peak_index;
  logic [SAMPLE_SIZE-1:0]             peak_mag;
  logic                               out_valid;
  logic                               out_ready;
  logic [15:0]                        frame_count;
  logic [SAMPLE_SIZE-1:0]             peak_threshold;
`ifdef FFT_PEAK_THRESHOLD_EN
  logic                               peak_found;
`endif

  fft_peak_bin_finder #(
    .SAMPLE_SIZE(SAMPLE_SIZE),
    .BUFFER_SIZE(BUFFER_SIZE),
    .NUM_BINS(NUM_BINS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_mags(in_mags),
    .in_valid(in_valid),
    .in_ready(in_ready),
`ifdef FFT_PEAK_THRESHOLD_EN
    .peak_threshold(peak_threshold),
    .peak_found(peak_found),
`endif
    .peak_index(peak_index),
    .peak_mag(peak_mag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [31:0] mag;
    int          fc;
    bit          found;
  } exp_t;

  exp_t        exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] frame_bins[NUM_BINS];
  int          model_fc = 0;
  int          hold_len = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Frame-level model: the largest magnitude anywhere in the frame, earliest bin on ties.
  function automatic exp_t model_frame(input logic [31:0] thr);
    exp_t e;
    e.idx = 0;
    e.mag = frame_bins[0];
    for (int i = 1; i < NUM_BINS; i++) begin
      if (frame_bins[i] > e.mag) begin
        e.idx = i;
        e.mag = frame_bins[i];
      end
    end
    e.found = (e.mag > thr);
    e.fc    = 0;
    return e;
  endfunction

  // Drive one frame; abort_after > 0 asserts reset once that many beats have gone in.
  task automatic applyStimulus(input int bubble_mode, input logic [31:0] thr_first,
                               input logic [31:0] thr_later, input int abort_after);
    exp_t e;
    int   waitc;
    e = model_frame(thr_first);
    waitc = 0;
    while (!in_ready && waitc < 100) begin
      @(negedge clk);
      waitc++;
    end
    if (!in_ready) begin
      checkOutput("in_ready_timeout", 64'(in_ready), 64'd1);
      return;
    end
    for (int b = 0; b < BEATS; b++) begin
      if (abort_after > 0 && b == abort_after) begin
        in_valid = 1'b0;
        reset    = 1'b1;
        model_fc = 0;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abort_out_valid", 64'(out_valid), 64'd0);
        checkOutput("abort_frame_count", 64'(frame_count), 64'd0);
        checkOutput("abort_in_ready", 64'(in_ready), 64'd1);
        checkOutput("abort_peak_index", 64'(peak_index), 64'd0);
        return;
      end
      if (b > 0 && (bubble_mode == 1 || (bubble_mode == 2 && $urandom_range(0, 2) == 0))) begin
        in_valid = 1'b0;
        peak_threshold = $urandom;
        @(negedge clk);
      end
      in_valid = 1'b1;
      for (int k = 0; k < BUFFER_SIZE; k++)
        in_mags[k*SAMPLE_SIZE +: SAMPLE_SIZE] = frame_bins[b*BUFFER_SIZE + k];
      peak_threshold = (b == 0) ? thr_first : thr_later;
      if (b == BEATS - 1) begin
        model_fc = (model_fc + 1) & 16'hFFFF;
        e.fc = model_fc;
        exp_q.push_back(e);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    checkOutput("latency_out_valid", 64'(out_valid), 64'd1);
  endtask

  // Monitor: pop the expected result on each new output, hold off the handshake, check stability.
  initial begin
    exp_t e;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && out_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_output", 64'(out_valid), 64'd0);
          out_ready = 1'b1;
          @(negedge clk);
          out_ready = 1'b0;
        end else begin
          e = exp_q.pop_front();
          checkOutput("peak_index", 64'(peak_index), 64'(e.idx));
          checkOutput("peak_mag", 64'(peak_mag), 64'(e.mag));
          checkOutput("frame_count", 64'(frame_count), 64'(e.fc));
`ifdef FFT_PEAK_THRESHOLD_EN
          checkOutput("peak_found", 64'(peak_found), 64'(e.found));
`endif
          for (int i = 0; i < hold_len; i++) begin
            @(negedge clk);
            checkOutput("hold_out_valid", 64'(out_valid), 64'd1);
            checkOutput("hold_in_ready", 64'(in_ready), 64'd0);
            checkOutput("hold_peak_index", 64'(peak_index), 64'(e.idx));
            checkOutput("hold_peak_mag", 64'(peak_mag), 64'(e.mag));
          end
          out_ready = 1'b1;
          @(negedge clk);
          out_ready = 1'b0;
          checkOutput("release_out_valid", 64'(out_valid), 64'd0);
          checkOutput("release_in_ready", 64'(in_ready), 64'd1);
          checkOutput("persist_peak_index", 64'(peak_index), 64'(e.idx));
          checkOutput("persist_peak_mag", 64'(peak_mag), 64'(e.mag));
        end
      end
    end
  end

  // Watchdog so a stuck handshake can never hang the run.
  initial begin
    #500000;
    failures++;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: directed frames from the test plan, then randomized frames.
  initial begin
    int          waitc;
    logic [31:0] thr;
    reset          = 1'b1;
    in_valid       = 1'b0;
    in_mags        = '0;
    peak_threshold = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_peak_index", 64'(peak_index), 64'd0);
    checkOutput("reset_peak_mag", 64'(peak_mag), 64'd0);
    checkOutput("reset_frame_count", 64'(frame_count), 64'd0);
`ifdef FFT_PEAK_THRESHOLD_EN
    checkOutput("reset_peak_found", 64'(peak_found), 64'd0);
`endif

    // Ramp
    hold_len = 1;
    for (int i = 0; i < NUM_BINS; i++) frame_bins[i] = i;
    applyStimulus(0, 32'd0, 32'd0, 0);

    // Ties across beats, then within a beat
    for (int i = 0; i < NUM_BINS; i++) frame_bins[i] = 7;
    frame_bins[5] = 1000; frame_bins[22] = 1000;
    applyStimulus(0, 32'd0, 32'd0, 0);
    for (int i = 0; i < NUM_BINS; i++) frame_bins[i] = 7;
    frame_bins[4] = 1000; frame_bins[5] = 1000;
    applyStimulus(0, 32'd0, 32'd0, 0);

    // Bubbles and output backpressure, then a follow-up frame
    hold_len = 5;
    for (int i = 0; i < NUM_BINS; i++) frame_bins[i] = $urandom_range(0, 400);
    applyStimulus(1, 32'd0, 32'd0, 0);
    for (int i = 0; i < NUM_BINS; i++) frame_bins[i] = $urandom_range(0, 499);
    frame_bins[17] = 500;
    applyStimulus(1, 32'd0, 32'd0, 0);

    // Reset mid-frame, then a fresh frame
    hold_len = 2;
    waitc = 0;
    while ((exp_q.size() != 0 || out_valid) && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    for (int i = 0; i < NUM_BINS; i++) frame_bins[i] = 3;
    frame_bins[9] = 5000;
    applyStimulus(0, 32'd0, 32'd0, 3);
    for (int i = 0; i < NUM_BINS; i++) frame_bins[i] = $urandom_range(0, 98);
    frame_bins[30] = 99;
    applyStimulus(0, 32'd0, 32'd0, 0);

    // Unsigned extremes
    for (int i = 0; i < NUM_BINS; i++) frame_bins[i] = 32'hFFFF_FFFE;
    frame_bins[12] = 32'hFFFF_FFFF;
    applyStimulus(2, 32'd0, 32'd0, 0);

    // Threshold behaviour (magnitude results are checked in every build)
    for (int i = 0; i < NUM_BINS; i++) frame_bins[i] = $urandom_range(0, 99);
    frame_bins[20] = 100;
    applyStimulus(0, 32'd100, 32'd100, 0);
    applyStimulus(0, 32'd99, 32'd99, 0);
    applyStimulus(2, 32'd200, 32'd0, 0);
    applyStimulus(2, 32'd0, 32'd500, 0);

    // Randomized frames
    for (int f = 0; f < 25; f++) begin
      int mode;
      mode = $urandom_range(0, 2);
      for (int i = 0; i < NUM_BINS; i++) begin
        case (mode)
          0:       frame_bins[i] = $urandom_range(0, 3);
          1:       frame_bins[i] = $urandom;
          default: frame_bins[i] = 32'hFFFF_FFF0 + $urandom_range(0, 15);
        endcase
      end
      hold_len = $urandom_range(0, 5);
      thr = (mode == 0) ? 32'($urandom_range(0, 4)) : $urandom;
      applyStimulus($urandom_range(0, 2), thr, $urandom, 0);
    end

    waitc = 0;
    while ((exp_q.size() != 0 || out_valid) && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    checkOutput("drain_pending", 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
